// File: rtl/wave_pipe_ctrl.sv
// Flow controller for the wave_former pipeline: stage valids, shared enable, priming and flush.
// Optional WAVE_PIPE_STATS_EN adds saturating stall_cnt / drop_cnt outputs.
module wave_pipe_ctrl #(
  parameter int LATENCY   = 4,
  parameter int PRIME_LEN = 16,
  parameter int CNT_W     = (PRIME_LEN > 0) ? $clog2(PRIME_LEN + 1) : 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        enable,
  input  logic        flush,
  output logic        dl_clear,
  output logic        delay_valid,
  output logic        busy
`ifdef WAVE_PIPE_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam logic [1:0] ST_PRIME = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  // With no priming the block starts (and re-enters after flush) directly streaming.
  localparam logic [1:0] ST_INIT    = (PRIME_LEN == 0) ? ST_RUN : ST_PRIME;
  localparam logic       PRIMED_INIT = (PRIME_LEN == 0);
  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'((PRIME_LEN > 0) ? PRIME_LEN - 1 : 0);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   prime_cnt_q, prime_cnt_d;
  logic               primed_q, primed_d;
  logic               dl_clear_q, dl_clear_d;
  logic               out_vld, drop;

  assign out_vld     = vld_q[LATENCY-1];
  assign enable      = !out_vld || m_ready || !primed_q;
  assign s_ready     = enable && (state_q != ST_FLUSH) && !flush;
  assign m_valid     = out_vld && primed_q;
  assign delay_valid = primed_q;
  assign dl_clear    = dl_clear_q;
  assign busy        = (|vld_q) || (state_q != ST_RUN);
  assign drop        = out_vld && !primed_q && enable;

  always_comb begin
    vld_d       = vld_q;
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    primed_d    = primed_q;
    dl_clear_d  = 1'b0;
    if (enable) begin
      vld_d[0] = s_valid && s_ready;
      for (int i = 1; i < LATENCY; i++) vld_d[i] = vld_q[i-1];
    end
    case (state_q)
      ST_PRIME, ST_RUN: begin
        if (state_q == ST_PRIME && drop) begin
          if (prime_cnt_q == PRIME_LAST) begin
            primed_d    = 1'b1;
            prime_cnt_d = '0;
            state_d     = ST_RUN;
          end else begin
            prime_cnt_d = prime_cnt_q + CNT_W'(1);
          end
        end
        if (flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // In-flight samples drain with whatever primed status they had.
        if (vld_q == '0) begin
          dl_clear_d  = 1'b1;
          state_d     = ST_INIT;
          primed_d    = PRIMED_INIT;
          prime_cnt_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      state_q     <= ST_INIT;
      prime_cnt_q <= '0;
      primed_q    <= PRIMED_INIT;
      dl_clear_q  <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
      dl_clear_q  <= dl_clear_d;
    end
  end

`ifdef WAVE_PIPE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (!enable && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (drop && drop_cnt_q != 16'hFFFF)     drop_cnt_d  = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_wave_pipe_ctrl.sv
// Bench for wave_pipe_ctrl: directed steps plus random traffic against a sample-ordinal model.
module tb_wave_pipe_ctrl;
  localparam int LAT = 4;
  localparam int PL  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: no priming, free-running stream
  logic a_reset, a_s_valid, a_m_ready, a_flush;
  logic a_s_ready, a_m_valid, a_enable, a_dl_clear, a_delay_valid, a_busy;
  // DUT B: priming depth PL, main target
  logic reset, s_valid, m_ready, flush;
  logic s_ready, m_valid, enable, dl_clear, delay_valid, busy;
`ifdef WAVE_PIPE_STATS_EN
  logic [15:0] a_stall_cnt, a_drop_cnt, stall_cnt, drop_cnt;
`endif

  wave_pipe_ctrl #(.LATENCY(LAT), .PRIME_LEN(0)) u_a (
    .clk(clk), .reset(a_reset), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .enable(a_enable), .flush(a_flush),
    .dl_clear(a_dl_clear), .delay_valid(a_delay_valid), .busy(a_busy)
`ifdef WAVE_PIPE_STATS_EN
    , .stall_cnt(a_stall_cnt), .drop_cnt(a_drop_cnt)
`endif
  );

  wave_pipe_ctrl #(.LATENCY(LAT), .PRIME_LEN(PL)) u_b (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready), .enable(enable), .flush(flush),
    .dl_clear(dl_clear), .delay_valid(delay_valid), .busy(busy)
`ifdef WAVE_PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
`endif
  );

  int n_cmp = 0, n_bad = 0;
  // Reference model: each stage slot holds the in-epoch ordinal of its sample, -1 if empty.
  // A sample is deliverable iff its ordinal >= PL.
  int dp [LAT];
  int ord, hs, acc_n, n_dlc, m_stalls, m_drops;
  bit flushing, mprimed, dlc;
  bit a_on = 0;
  int a_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (dp[i]) dp[i] = -1;
    ord = 0; flushing = 0; mprimed = (PL == 0); dlc = 0;
    m_stalls = 0; m_drops = 0;
  endtask

  task automatic sample();
    int  head;
    bit  out, emv, een, esr, empty, drop, dlc_n;
    head = dp[LAT-1];
    out  = head >= 0;
    emv  = out && head >= PL;
    een  = !emv || m_ready;
    esr  = een && !flushing && !flush;
    empty = 1;
    foreach (dp[i]) if (dp[i] >= 0) empty = 0;
    chk("m_valid", m_valid, emv);
    chk("enable", enable, een);
    chk("s_ready", s_ready, esr);
    chk("dl_clear", dl_clear, dlc);
    chk("delay_valid", delay_valid, mprimed);
    chk("busy", busy, !empty || flushing || !mprimed);
    if (a_on && a_cyc < 12) begin
      chk("a_m_valid", a_m_valid, a_cyc >= LAT);
      chk("a_enable", a_enable, 1);
      a_cyc++;
    end
    if (m_valid && m_ready) hs++;
    if (dl_clear) n_dlc++;
    drop = out && !emv && een;
    if (!een) m_stalls++;
    if (drop) m_drops++;
    if (reset) begin
      model_reset();
    end else begin
      dlc_n = flushing && empty;
      if (dlc_n) begin
        flushing = 0;
        mprimed  = (PL == 0);
      end else if (flush && !flushing) begin
        flushing = 1;
        ord      = 0;
      end
      if (drop && head == PL - 1) mprimed = 1;
      dlc = dlc_n;
      if (een) begin
        for (int i = LAT - 1; i > 0; i--) dp[i] = dp[i-1];
        if (s_valid && esr) begin
          dp[0] = ord; ord++; acc_n++;
        end else begin
          dp[0] = -1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int hs0, acc0, d0;
    int k;
`ifdef WAVE_PIPE_STATS_EN
    int st0;
`endif
    hs = 0; acc_n = 0; n_dlc = 0;
    model_reset();
    reset = 1; s_valid = 0; m_ready = 1; flush = 0;
    a_reset = 1; a_s_valid = 1; a_m_ready = 1; a_flush = 0;
    @(posedge clk); #1;
    steps(2);
    reset = 0; a_reset = 0; a_on = 1;

    // Priming: 10 samples, the first PL are dropped
    hs0 = hs;
    s_valid = 1; steps(10);
    s_valid = 0; steps(12);
    chk("prime_handshakes", hs - hs0, 10 - PL);
    chk("primed_after_stream", delay_valid, 1);

    // Backpressure: hold m_ready low for 5 cycles while a result waits
    hs0 = hs; acc0 = acc_n;
    s_valid = 1;
    k = 0;
    while (!m_valid && k < 10) begin step(); k++; end
    chk("stall_setup_m_valid", m_valid, 1);
    m_ready = 0;
`ifdef WAVE_PIPE_STATS_EN
    st0 = stall_cnt;
`endif
    steps(5);
`ifdef WAVE_PIPE_STATS_EN
    chk("stall_cnt_plus5", stall_cnt - st0, 5);
`endif
    m_ready = 1; s_valid = 0; steps(10);
    chk("stall_no_loss", hs - hs0, acc_n - acc0);

    // Flush in RUN with 2 samples in flight
    hs0 = hs; d0 = n_dlc;
    s_valid = 1; steps(2);
    flush = 1; step();
    flush = 0; s_valid = 0;
    k = 0;
    while (n_dlc == d0 && k < 20) begin step(); k++; end
    chk("flush_dlc_seen", n_dlc - d0, 1);
    chk("flush_delivered", hs - hs0, 2);
    steps(3);
    chk("flush_dlc_once", n_dlc - d0, 1);
    chk("flush_unprimed", delay_valid, 0);

    // Flush with an empty pipeline: dl_clear lands 2 cycles later
    flush = 1; step();
    flush = 0;
    chk("empty_flush_t1_dlc", dl_clear, 0);
    chk("empty_flush_t1_busy", busy, 1);
    step();
    chk("empty_flush_t2_dlc", dl_clear, 1);
    steps(2);

    // Reset mid-stream with 3 samples in flight
    s_valid = 1; steps(6);
    s_valid = 0; steps(6);
    s_valid = 1; steps(3);
    s_valid = 0; reset = 1; step();
    reset = 0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_delay_valid", delay_valid, 0);
    chk("rst_busy", busy, 1);
    hs0 = hs;
    steps(8);
    chk("rst_no_delivery", hs - hs0, 0);

    // Random traffic; flushes only once the stream is primed
    for (int c = 0; c < 800; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = (mprimed || flushing) && ($urandom_range(0, 39) == 0);
      step();
    end
    s_valid = 0; flush = 0; m_ready = 1;
    steps(20);
    chk("final_idle_m_valid", m_valid, 0);
`ifdef WAVE_PIPE_STATS_EN
    chk("stall_cnt_total", stall_cnt, m_stalls);
    chk("drop_cnt_total", drop_cnt, m_drops);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
